arm_mc_controller: RTL
======================

Name: arm_mc_controller

Overview:
- Control unit for the multicycle ARM datapath: the single-cycle datapath split over shared memory, with instruction, data, A/WriteData and ALUOut registers.
- Holds the instruction-sequencing FSM, the NZCV flag register and condition evaluation.
- Drives every select and write enable for the datapath, one state per cycle.
- Supports ADD/SUB (reg or imm, S bit), AND/ORR (reg, S bit), CMP, LDR/STR (imm offset, P=1 U=1 W=0) and B.

Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Instr  in  32  instruction register contents
- ALUFlags  in  4  combinational {N,Z,C,V} from ALU this cycle
- PCWrite  out  1  PC register load
- IRWrite  out  1  instruction register load
- MemWrite  out  1  memory write enable
- RegWrite  out  1  register file write enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- RegSrc  out  2  [0]: RA1=15; [1]: RA2=Instr[15:12]
- ALUSrcA  out  1  0=A register, 1=PC
- ALUSrcB  out  2  00=WriteData register, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data register, 10=ALUResult
- ImmSrc  out  2  00=imm8, 01=imm12, 10=branch imm24
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Flags  out  4  current {N,Z,C,V} register
- State  out  4  FSM state code, for debug

Behaviour:
- **Reset**
  - rst high at posedge: State <= FETCH, Flags <= 0000.
  - While rst is high, PCWrite, IRWrite, MemWrite and RegWrite are forced 0.
  - rst has priority mid-instruction; a partially executed instruction is abandoned.
- **Outputs**
  - All outputs are combinational from State and Instr.
  - Any output not listed for a state is 0.
  - RegSrc and ImmSrc are decoded from Instr in every state: B → RegSrc=01, ImmSrc=10; LDR/STR → RegSrc=10, ImmSrc=01; else 00/00.
- **State codes:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- **FETCH:** AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 → DECODE.
- **DECODE**
  - Outputs: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (forms PC+8, no writes).
  - CondEx evaluated from the Flags register on Instr[31:28]:
    - EQ: Z
    - NE: !Z
    - GE: N==V
    - LT: N!=V
    - GT: !Z & N==V
    - LE: Z | N!=V
    - all other codes: true
  - CondEx=0 → FETCH (instruction skipped).
  - Else: LDR/STR → MEMADR; B → BRANCH; data-processing with I=1 → EXECI; I=0 → EXECR; unrecognised → FETCH.
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. Instr[20]=1 → MEMRD, else → MEMWR.
- **MEMRD:** AdrSrc=1, ResultSrc=00 → MEMWB.
- **MEMWB:** ResultSrc=01; write Rd → FETCH.
- **MEMWR:** AdrSrc=1, ResultSrc=00, MemWrite=1 → FETCH.
- **EXECR / EXECI**
  - Outputs: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl from cmd (ADD 0100, SUB 0010, CMP 1010, AND 0000, ORR 1100).
  - Flag update at the clock edge leaving this state:
    - S=1 ADD/SUB, or CMP: all of NZCV ← ALUFlags.
    - S=1 AND/ORR: NZ only.
    - Otherwise flags are held.
  - CMP → FETCH; else → ALUWB.
- **ALUWB:** ResultSrc=00; write Rd → FETCH.
- **Rd writes (MEMWB, ALUWB):**
  - Rd (Instr[15:12]) != 15 → RegWrite=1.
  - Rd == 15 → PCWrite=1, RegWrite=0.
- **BRANCH:** ALUSrcA=0 (A holds PC+8 via RegSrc[0]), ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1 → FETCH.
- **Cycle counts, FETCH to next FETCH:**
  - skipped: 2
  - B: 3
  - CMP: 3
  - STR: 4
  - ALU: 4
  - LDR: 5
- Flags never change outside EXECR/EXECI.

Test Plan:
- **Reset:** rst high 2 cycles, with Instr and ALUFlags arbitrary → State=0, Flags=0000, all write enables 0 throughout. The first cycle after release has PCWrite=IRWrite=1.
- **ADD immediate:** ADD R1,R0,#5 (E2801005) → States 0,1,7,8. In EXECI, ALUSrcB=01 and ALUControl=00. In ALUWB, RegWrite=1. Flags unchanged.
- **SUBS/BEQ:** SUBS (E2500001) with ALUFlags=0100 in EXECI → Flags=0100. Then BEQ (0A000002) → States 0,1,9 with PCWrite=1 in state 9. Repeat with Flags=0000 → 0,1,0, no PCWrite in state 1.
- **LDR/STR:**
  - LDR R2,[R0,#8] (E5902008) → States 0,1,2,3,4. In MEMRD, AdrSrc=1. In MEMWB, ResultSrc=01 and RegWrite=1.
  - STR (E5802008) → 0,1,2,5 with MemWrite=1 only in state 5.
- **Logical S and CMP:**
  - ANDS with ALUFlags=1011 when Flags=0001 → Flags=1001 (C, V kept).
  - CMP with ALUFlags=1000 → Flags=1000, path 0,1,6,0, RegWrite never asserted.
  - Then BLT (BA000000) is taken and BGE is skipped.
- **Rd=15 and reset mid-instruction:**
  - ADD PC,R0,R1 (E080F001) → ALUWB asserts PCWrite=1, RegWrite=0.
  - rst asserted in MEMRD → State=0 next cycle, no RegWrite ever asserted.

Source files
------------

// File: rtl/arm_mc_controller.sv
// Control unit for the multicycle ARM datapath.
// Sequences each instruction through FETCH/DECODE and the class-specific
// execute states, keeps the NZCV flag register and evaluates the condition
// field. Every datapath select and write enable is a combinational function
// of the current state and the instruction register contents.
module arm_mc_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ALUControl,
   output logic [3:0]  Flags,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   state_t     state_q;
   logic [3:0] flags_q;
   logic [3:0] flags_d;

   // Instruction fields
   logic [3:0] cond;
   logic [1:0] op;
   logic       funct_i;
   logic [3:0] cmd;
   logic       s_bit;
   logic [3:0] rd;

   assign cond    = Instr[31:28];
   assign op      = Instr[27:26];
   assign funct_i = Instr[25];
   assign cmd     = Instr[24:21];
   assign s_bit   = Instr[20];   // S for data processing, L for memory
   assign rd      = Instr[15:12];

   // Register numbers and immediates are datapath business, not ours.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

   // Instruction class decode
   logic is_dp, is_mem, is_br;
   logic cmd_add, cmd_sub, cmd_cmp, cmd_and, cmd_orr, dp_known;
   logic rd_is_pc;

   assign is_dp    = (op == 2'b00);
   assign is_mem   = (op == 2'b01);
   assign is_br    = (op == 2'b10);

   assign cmd_add  = (cmd == 4'b0100);
   assign cmd_sub  = (cmd == 4'b0010);
   assign cmd_cmp  = (cmd == 4'b1010);
   assign cmd_and  = (cmd == 4'b0000);
   assign cmd_orr  = (cmd == 4'b1100);
   assign dp_known = cmd_add | cmd_sub | cmd_cmp | cmd_and | cmd_orr;

   assign rd_is_pc = (rd == 4'hF);

   // RegSrc/ImmSrc follow the instruction class in every state so the
   // register file and extender are already set up while decoding.
   assign RegSrc = is_br  ? 2'b01 :
                   is_mem ? 2'b10 : 2'b00;
   assign ImmSrc = is_br  ? 2'b10 :
                   is_mem ? 2'b01 : 2'b00;

   // Condition check against the stored flags
   logic flag_n, flag_z, flag_v;
   logic cond_ex;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_v = flags_q[0];

   // Evaluate the condition field; unlisted codes always execute
   always_comb begin
      cond_ex = 1'b1;
      case (cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         default: cond_ex = 1'b1;
      endcase
   end

   // ALU operation for the execute states
   logic [1:0] dp_alu_ctl;

   // Map the data-processing command to the ALU operation
   always_comb begin
      dp_alu_ctl = 2'b00;
      if (cmd_sub || cmd_cmp) dp_alu_ctl = 2'b01;
      else if (cmd_and)       dp_alu_ctl = 2'b10;
      else if (cmd_orr)       dp_alu_ctl = 2'b11;
   end

   // Flag update captured on the edge leaving an execute state; logical
   // operations leave C and V alone.
   always_comb begin
      flags_d = flags_q;
      if (state_q == EXECR || state_q == EXECI) begin
         if ((s_bit && (cmd_add || cmd_sub)) || cmd_cmp)
            flags_d = ALUFlags;
         else if (s_bit && (cmd_and || cmd_orr))
            flags_d = {ALUFlags[3:2], flags_q[1:0]};
      end
   end

   // Instruction sequencer and flag register; reset abandons any
   // partially executed instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
         case (state_q)
            FETCH:  state_q <= DECODE;
            DECODE: begin
               if (!cond_ex)               state_q <= FETCH;
               else if (is_mem)            state_q <= MEMADR;
               else if (is_br)             state_q <= BRANCH;
               else if (is_dp && dp_known) state_q <= funct_i ? EXECI : EXECR;
               else                        state_q <= FETCH;
            end
            MEMADR: state_q <= s_bit ? MEMRD : MEMWR;
            MEMRD:  state_q <= MEMWB;
            MEMWB:  state_q <= FETCH;
            MEMWR:  state_q <= FETCH;
            EXECR:  state_q <= cmd_cmp ? FETCH : ALUWB;
            EXECI:  state_q <= cmd_cmp ? FETCH : ALUWB;
            ALUWB:  state_q <= FETCH;
            BRANCH: state_q <= FETCH;
            default: state_q <= FETCH;
         endcase
      end
   end

   // Write enables before reset gating
   logic pc_we, ir_we, mem_we, reg_we;

   // Per-state datapath controls; anything not set for a state stays 0
   always_comb begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
      case (state_q)
         FETCH: begin
            // Read instruction at PC, PC <= PC+4
            AdrSrc    = 1'b0;
            ir_we     = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            pc_we     = 1'b1;
         end
         DECODE: begin
            // PC+4 again gives PC+8 for R15 reads, nothing written
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: begin
            ALUSrcA = 1'b0;
            ALUSrcB = 2'b01;
         end
         MEMRD: begin
            AdrSrc    = 1'b1;
            ResultSrc = 2'b00;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            pc_we     = rd_is_pc;
            reg_we    = ~rd_is_pc;
         end
         MEMWR: begin
            AdrSrc    = 1'b1;
            ResultSrc = 2'b00;
            mem_we    = 1'b1;
         end
         EXECR: begin
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUControl = dp_alu_ctl;
         end
         EXECI: begin
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b01;
            ALUControl = dp_alu_ctl;
         end
         ALUWB: begin
            ResultSrc = 2'b00;
            pc_we     = rd_is_pc;
            reg_we    = ~rd_is_pc;
         end
         BRANCH: begin
            // A holds PC+8 because RegSrc[0] selects R15 for RA1
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            pc_we     = 1'b1;
         end
         default: begin
            pc_we = 1'b0;
         end
      endcase
   end

   // No architectural state may change while reset is held
   assign PCWrite  = pc_we  & ~rst;
   assign IRWrite  = ir_we  & ~rst;
   assign MemWrite = mem_we & ~rst;
   assign RegWrite = reg_we & ~rst;

   assign Flags = flags_q;
   assign State = state_q;

endmodule
